// File: rtl/hdmi_timing_ctrl_pkg.sv
// hdmi_timing_pkg: shared types and default 640x480@60 timing for the video
// timing sequencer.
//   - DEF_* : default porch/sync/active sizes and derived totals
//   - state_t : sequencer state
//   - vid_ctl_t : per-pixel control bundle carried down the output delay line
package hdmi_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
      logic ls;
   } vid_ctl_t;

   // True when v lies in the half-open window [lo, lo+len).
   function automatic logic in_win(input int v, input int lo, input int len);
      return (v >= lo) && (v < lo + len);
   endfunction

endpackage

// File: rtl/hdmi_timing_ctrl_sync_delay_line.sv
// sync_delay_line: DEPTH-stage, WIDTH-bit shift register, shifting every cycle.
//   clk, rst : clock, async active-high reset (all stages load RST_VAL)
//   din      : value entering stage 0
//   dout     : value leaving stage DEPTH-1 (DEPTH cycles after din)
module sync_delay_line #(
   parameter int               DEPTH   = 2,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= {DEPTH{RST_VAL}};
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: video raster sequencer in front of the TMDS encoders.
//   clk, rst     : pixel clock, async active-high reset
//   en           : run request (stops only on a frame boundary)
//   clr_err      : clears the sticky underflow flag
//   pix_valid    : pixel source has data for the current output cycle
//   pix_req/x/y  : pixel request with coordinates, one cycle after the counters
//   draw_area, hsync, vsync, frame_start, line_start : PIPE_DLY after counters
//   busy         : sequencer not idle
//   underflow    : sticky, draw_area seen without pix_valid
// PIPE_DLY must be >= 1 and H/V totals must fit in CW bits.
module hdmi_timing_ctrl
   import hdmi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = 1,
   parameter int PIPE_DLY = 2,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr_err,
   input  logic          pix_valid,
   output logic          pix_req,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          draw_area,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start,
   output logic          line_start,
   output logic          busy,
   output logic          underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [CW-1:0] HT_M1 = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] VT_M1 = CW'(V_TOTAL - 1);
   localparam logic POL = (SYNC_POL != 0);

   state_t        state, state_nxt;
   logic [CW-1:0] cntx, cnty;
   logic          run, x_last, frame_last;
   vid_ctl_t      s0, dly;

   assign run        = (state != IDLE);
   assign x_last     = (cntx == HT_M1);
   assign frame_last = x_last && (cnty == VT_M1);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = DRAIN;
         // A late en on the final cycle keeps the raster going seamlessly.
         DRAIN:   if (en) state_nxt = RUN;
                  else if (frame_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- raster counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cntx <= '0;
         cnty <= '0;
      end else if (!run) begin
         cntx <= '0;
         cnty <= '0;
      end else if (x_last) begin
         cntx <= '0;
         cnty <= (cnty == VT_M1) ? '0 : cnty + 1'b1;
      end else begin
         cntx <= cntx + 1'b1;
      end
   end

   // ---------------- stage-0 decode ----------------
   always_comb begin
      s0    = '0;
      s0.de = run && (int'(cntx) < H_ACTIVE) && (int'(cnty) < V_ACTIVE);
      s0.hs = run && in_win(int'(cntx), H_ACTIVE + H_FP, H_SYNC);
      s0.vs = run && in_win(int'(cnty), V_ACTIVE + V_FP, V_SYNC);
      s0.ls = s0.de && (cntx == '0);
      s0.fs = s0.ls && (cnty == '0);
   end

   // ---------------- request stage ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_req <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
      end else begin
         pix_req <= s0.de;
         pix_x   <= s0.de ? cntx : '0;
         pix_y   <= s0.de ? cnty : '0;
      end
   end

   // ---------------- output alignment ----------------
   // Keeps shifting in IDLE so the tail of a drained frame still reaches the pins.
   sync_delay_line #(
      .DEPTH   (PIPE_DLY),
      .WIDTH   ($bits(vid_ctl_t)),
      .RST_VAL ('0)
   ) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (s0),
      .dout (dly)
   );

   assign draw_area   = dly.de;
   assign hsync       = dly.hs ~^ POL;
   assign vsync       = dly.vs ~^ POL;
   assign frame_start = dly.fs;
   assign line_start  = dly.ls;
   assign busy        = run;

   // ---------------- underflow (set beats clear) ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) underflow <= 1'b0;
      else     underflow <= (draw_area && !pix_valid) || (underflow && !clr_err);
   end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench: instance a uses default 640x480 timing (active-high sync),
// instance b uses a 16x10 raster (8x6 active, active-low sync) so whole
// frames, drain and restart fit in a short run.
module tb_hdmi_timing_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instance a: defaults ----------------
   logic       rst_a, en_a, clr_a, pv_a;
   logic       req_a, de_a, hs_a, vs_a, fs_a, ls_a, busy_a, uf_a;
   logic [9:0] x_a, y_a;

   hdmi_timing_ctrl u_a (
      .clk(clk), .rst(rst_a), .en(en_a), .clr_err(clr_a), .pix_valid(pv_a),
      .pix_req(req_a), .pix_x(x_a), .pix_y(y_a), .draw_area(de_a),
      .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .line_start(ls_a),
      .busy(busy_a), .underflow(uf_a)
   );

   // ---------------- instance b: small raster, active-low sync ----------------
   logic       rst_b, en_b, clr_b, pv_b;
   logic       req_b, de_b, hs_b, vs_b, fs_b, ls_b, busy_b, uf_b;
   logic [9:0] x_b, y_b;

   hdmi_timing_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(0), .PIPE_DLY(2), .CW(10)
   ) u_b (
      .clk(clk), .rst(rst_b), .en(en_b), .clr_err(clr_b), .pix_valid(pv_b),
      .pix_req(req_b), .pix_x(x_b), .pix_y(y_b), .draw_area(de_b),
      .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b), .line_start(ls_b),
      .busy(busy_b), .underflow(uf_b)
   );

   initial begin
      int dcnt, hfirst, hlast, lcnt, fcnt, hlow, vlow, vfirst, vlast, ucnt, nidle, bzero;
      rst_a = 1; en_a = 0; clr_a = 0; pv_a = 1;
      rst_b = 1; en_b = 0; clr_b = 0; pv_b = 1;
      repeat (3) tick();

      // reset values
      chk("a_rst_req",  int'(req_a),  0);
      chk("a_rst_de",   int'(de_a),   0);
      chk("a_rst_hs",   int'(hs_a),   0);
      chk("a_rst_vs",   int'(vs_a),   0);
      chk("a_rst_busy", int'(busy_a), 0);
      chk("a_rst_uf",   int'(uf_a),   0);
      chk("b_rst_hs",   int'(hs_b),   1);
      chk("b_rst_vs",   int'(vs_b),   1);
      chk("b_rst_de",   int'(de_b),   0);

      rst_a = 0; rst_b = 0;
      tick(); tick();
      chk("a_idle_busy", int'(busy_a), 0);
      chk("b_idle_hs",   int'(hs_b),   1);
      chk("b_idle_vs",   int'(vs_b),   1);

      // ---- a: start, first request/output latency ----
      en_a = 1;
      tick();
      chk("a_busy_t1", int'(busy_a), 1);
      chk("a_req_t1",  int'(req_a),  0);
      tick();
      chk("a_req_t2", int'(req_a), 1);
      chk("a_x_t2",   int'(x_a),   0);
      chk("a_y_t2",   int'(y_a),   0);
      chk("a_de_t2",  int'(de_a),  0);
      tick();
      chk("a_fs_t3", int'(fs_a), 1);
      chk("a_de_t3", int'(de_a), 1);
      chk("a_ls_t3", int'(ls_a), 1);
      chk("a_x_t3",  int'(x_a),  1);

      // ---- a: one line ----
      dcnt = 0; hfirst = -1; hlast = -1; lcnt = 0; fcnt = 0;
      for (int k = 0; k < 800; k++) begin
         if (de_a) dcnt++;
         if (hs_a) begin
            if (hfirst < 0) hfirst = k;
            hlast = k;
         end
         if (ls_a) lcnt++;
         if (fs_a) fcnt++;
         if (k == 638) begin
            chk("a_req_638", int'(req_a), 1);
            chk("a_x_638",   int'(x_a),   639);
         end
         if (k == 639) begin
            chk("a_req_639", int'(req_a), 0);
            chk("a_x_639",   int'(x_a),   0);
         end
         tick();
      end
      chk("a_line_de",    dcnt,   640);
      chk("a_hs_first",   hfirst, 656);
      chk("a_hs_last",    hlast,  751);
      chk("a_line_ls",    lcnt,   1);
      chk("a_line_fs",    fcnt,   1);
      chk("a_ls_period",  int'(ls_a), 1);
      chk("a_fs_line1",   int'(fs_a), 0);
      chk("a_de_line1",   int'(de_a), 1);
      chk("a_y_line1",    int'(y_a),  1);
      chk("a_uf_line",    int'(uf_a), 0);

      // ---- a: async reset mid-line, then restart ----
      rst_a = 1;
      #1;
      chk("a_arst_de",   int'(de_a),   0);
      chk("a_arst_busy", int'(busy_a), 0);
      chk("a_arst_req",  int'(req_a),  0);
      chk("a_arst_y",    int'(y_a),    0);
      chk("a_arst_ls",   int'(ls_a),   0);
      tick();
      rst_a = 0;
      tick(); tick();
      chk("a_rerun_req", int'(req_a), 1);
      chk("a_rerun_x",   int'(x_a),   0);
      chk("a_rerun_y",   int'(y_a),   0);
      rst_a = 1;

      // ---- b: one full frame (160 cycles) ----
      en_b = 1;
      tick(); tick(); tick();
      dcnt = 0; fcnt = 0; hlow = 0; vlow = 0; vfirst = -1; vlast = -1; ucnt = 0;
      for (int k = 0; k < 160; k++) begin
         if (de_b) dcnt++;
         if (fs_b) fcnt++;
         if (!hs_b) hlow++;
         if (!vs_b) begin
            vlow++;
            if (vfirst < 0) vfirst = k;
            vlast = k;
         end
         if (uf_b) ucnt++;
         tick();
      end
      chk("b_frame_de",   dcnt,   48);
      chk("b_frame_fs",   fcnt,   1);
      chk("b_frame_hlow", hlow,   30);
      chk("b_frame_vlow", vlow,   32);
      chk("b_vs_first",   vfirst, 112);
      chk("b_vs_last",    vlast,  143);
      chk("b_frame_uf",   ucnt,   0);
      chk("b_fs_period",  int'(fs_b), 1);

      // ---- b: drop en at line 3 of frame 2, drain to idle ----
      repeat (46) tick();
      en_b = 0;
      nidle = -1; dcnt = 0; vlow = 0;
      for (int n = 1; n <= 400; n++) begin
         tick();
         if (!busy_b) begin
            nidle = n;
            break;
         end
         if (de_b) dcnt++;
         if (!vs_b) vlow++;
      end
      chk("b_drain_len",  nidle, 112);
      chk("b_drain_de",   dcnt,  24);
      chk("b_drain_vlow", vlow,  32);
      tick(); tick();
      chk("b_rest_hs", int'(hs_b), 1);
      chk("b_rest_vs", int'(vs_b), 1);
      chk("b_rest_de", int'(de_b), 0);
      fcnt = 0; bzero = 0;
      for (int n = 0; n < 20; n++) begin
         if (fs_b) fcnt++;
         if (busy_b) bzero++;
         tick();
      end
      chk("b_idle_fs",   fcnt,  0);
      chk("b_idle_busy", bzero, 0);

      // ---- b: restart, drop, re-raise on the final drain cycle ----
      en_b = 1;
      tick(); tick(); tick();
      fcnt = 0; dcnt = 0; bzero = 0;
      for (int k = 0; k <= 320; k++) begin
         if (fs_b) fcnt++;
         if (!busy_b) bzero++;
         if (de_b && k < 320) dcnt++;
         if (k == 46)  en_b = 0;
         if (k == 157) en_b = 1;
         if (k < 320) tick();
      end
      chk("b_cont_fs",   fcnt,  3);
      chk("b_cont_de",   dcnt,  96);
      chk("b_cont_busy", bzero, 0);

      // ---- b: underflow set / sticky / clear / set-beats-clear ----
      chk("b_uf_de0", int'(de_b), 1);
      pv_b = 0;
      tick();
      chk("b_uf_set", int'(uf_b), 1);
      pv_b = 1;
      tick();
      chk("b_uf_sticky", int'(uf_b), 1);
      clr_b = 1;
      tick();
      chk("b_uf_clr", int'(uf_b), 0);
      pv_b = 0;
      tick();
      chk("b_uf_setwins", int'(uf_b), 1);
      clr_b = 0; pv_b = 1;
      tick();
      chk("b_uf_hold", int'(uf_b), 1);

      // ---- b: async reset at counter (4,2) ----
      repeat (29) tick();
      chk("b_pre_req", int'(req_b), 1);
      chk("b_pre_x",   int'(x_b),   3);
      chk("b_pre_y",   int'(y_b),   2);
      chk("b_pre_de",  int'(de_b),  1);
      rst_b = 1;
      #1;
      chk("b_arst_req",  int'(req_b),  0);
      chk("b_arst_x",    int'(x_b),    0);
      chk("b_arst_y",    int'(y_b),    0);
      chk("b_arst_de",   int'(de_b),   0);
      chk("b_arst_fs",   int'(fs_b),   0);
      chk("b_arst_ls",   int'(ls_b),   0);
      chk("b_arst_busy", int'(busy_b), 0);
      chk("b_arst_uf",   int'(uf_b),   0);
      chk("b_arst_hs",   int'(hs_b),   1);
      chk("b_arst_vs",   int'(vs_b),   1);
      en_b = 0;
      tick();
      rst_b = 0;
      repeat (5) tick();
      chk("b_wait_busy", int'(busy_b), 0);
      chk("b_wait_req",  int'(req_b),  0);
      en_b = 1;
      tick(); tick();
      chk("b_rerun_req", int'(req_b), 1);
      chk("b_rerun_x",   int'(x_b),   0);
      chk("b_rerun_y",   int'(y_b),   0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hdmi_timing_ctrl.md
Name: hdmi_timing_ctrl

Overview:
Parameterised video timing sequencer that drives the pixel pipeline feeding the TMDS encoders and serializer.
- Generates the horizontal and vertical counters, and issues one-cycle-ahead pixel requests with coordinates to the pattern/pixel source.
- Produces draw_area/hsync/vsync delayed to line up with the pixel source's registered colour outputs.
- Supports clean start/stop on frame boundaries and flags pixel-source underflow.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = sum = 525
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
- PIPE_DLY, 2, cycles from counter state to draw_area/hsync/vsync outputs; must be >= 1
- CW, 10, counter/coordinate width; H_TOTAL and V_TOTAL must be <= 2^CW

Ports:
- clk  in  1  pixel clock (25 MHz at defaults)
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request; sampled every cycle
- clr_err  in  1  clears underflow
- pix_valid  in  1  pixel source has data for the current output cycle
- pix_req  out  1  pixel wanted for coordinates on pix_x/pix_y
- pix_x  out  CW  requested column
- pix_y  out  CW  requested line
- draw_area  out  1  active video, aligned to pixel data
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- frame_start  out  1  one-cycle pulse on the output cycle for pixel (0,0)
- line_start  out  1  one-cycle pulse on each output cycle with column 0
- busy  out  1  state != IDLE
- underflow  out  1  sticky error flag

Behaviour:
Reset values:
- Counters cntx = cnty = 0; state IDLE; delay line all inactive.
- pix_req, pix_x, pix_y, draw_area, frame_start, line_start, busy, underflow = 0.
- hsync = vsync = !SYNC_POL.

FSM:
- IDLE:
  - Counters held at 0.
  - en = 1 -> RUN; the first RUN cycle has counters at (0,0).
- RUN:
  - en = 0 -> DRAIN, with no counter interruption.
- DRAIN:
  - Counters keep running.
  - On the cycle with cntx = H_TOTAL-1 and cnty = V_TOTAL-1 -> IDLE.
  - en = 1 while in DRAIN -> RUN; the raster continues uninterrupted.
  - If en rises on the final cycle, that takes priority over returning to IDLE, so the next frame follows seamlessly.

Counters (advance in RUN and DRAIN):
- cntx wraps from H_TOTAL-1 to 0.
- cnty increments on each cntx wrap and wraps from V_TOTAL-1 to 0.

Stage-0 decode (combinational from the counters; forced inactive in IDLE):
- de0 = cntx < H_ACTIVE && cnty < V_ACTIVE.
- hs0 = cntx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vs0 = cnty in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- fs0 = de0 && cntx == 0 && cnty == 0.
- ls0 = de0 && cntx == 0.

Request stage:
- pix_req, pix_x, pix_y are registered from de0, cntx, cnty (1-cycle latency).
- pix_x and pix_y are 0 when pix_req = 0.

Output stage:
- {de, hs, vs, fs, ls} pass through a PIPE_DLY-deep shift register.
- The pixel source therefore has PIPE_DLY-1 cycles from pix_req to valid data.
- The delay line shifts every cycle. In IDLE it shifts in inactive values, so trailing output cycles after DRAIN -> IDLE still emit correctly.
- hsync = hs XNOR SYNC_POL, so the idle level is !SYNC_POL; vsync likewise.

Underflow:
- Set when draw_area = 1 && pix_valid = 0.
- clr_err clears it.
- If set and clear occur in the same cycle, set wins.

Mid-operation reset:
- All state returns to reset values immediately, with no frame completion.
- After reset the block stays IDLE until en is seen high.

Decomposition:
- Package hdmi_timing_pkg:
  - 640x480@60 default timing constants and derived H_TOTAL/V_TOTAL.
  - State enum {IDLE, RUN, DRAIN}.
  - Output-bundle struct {de, hs, vs, fs, ls}.
- Sub-module sync_delay_line: generic DEPTH x WIDTH shift register with async reset to a parameterised reset value.

Test Plan:
- Reset, then en = 1 at cycle T, with pix_valid = 1 throughout:
  - First pix_req at T+2 with (pix_x, pix_y) = (0,0).
  - frame_start and draw_area rise at T+1+PIPE_DLY = T+3.
  - Run one line: draw_area high for 640 cycles, hsync high from output column 656 through 751, line period 800 cycles.
- Full frame at defaults:
  - vsync high only on lines 490-491 (1600 cycles).
  - frame_start pulses exactly once per 420000 cycles.
  - No underflow.
- en dropped mid-frame at line 100:
  - busy stays 1 until counter state (799,524).
  - Output stream is completed PIPE_DLY cycles later, then hsync/vsync rest at 0.
  - en re-raised at line 300 gives continuous frames with no glitch.
- SYNC_POL = 0:
  - hsync/vsync idle high in IDLE and after reset.
  - Pulses are low over the same column/line windows.
- pix_valid forced 0 for one cycle inside the active area:
  - underflow = 1 next cycle and stays set.
  - clr_err with no new fault clears it.
  - clr_err coincident with a new fault leaves it at 1.
- Async reset asserted at (cntx, cnty) = (400,200) while running:
  - All outputs immediately return to their reset values.
  - After release with en = 1, the first pix_req is again at (0,0).
